multicycle_control: RTL and testbench

Parametrised multi-cycle control unit for the teaching CPU. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states instead of decoding the opcode in a single combinational step. It waits on a memory ready handshake with a timeout and traps on illegal opcodes. It sits between the instruction register and the datapath strobes: PC, instruction register, register file, ALU and data memory.

---
 rtl/multicycle_control_pkg.sv | 46 ++++
 rtl/multicycle_control_if.sv | 32 +++
 rtl/multicycle_control_decode.sv | 68 ++++++
 rtl/multicycle_control.sv | 142 ++++++++++++++
 tb/tb_multicycle_control.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit: state
// encoding, ALU operation codes, fault causes and the datapath strobe bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int DEF_OP_RTYPE  = 0;
  localparam int DEF_OP_LOAD   = 1;
  localparam int DEF_OP_STORE  = 2;
  localparam int DEF_OP_BRANCH = 3;

  typedef struct packed {
    logic       pcWrite;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] aluOp;
    logic       aluSrc;
    logic       branch;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
  } strobes_t;

  // A zero timeout still needs a one-bit counter so the register exists.
  function automatic int cntWidth(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit boundary: opcode and memory handshake in, datapath strobes
// and fault status out.
interface multicycle_control_if #(
  parameter int OP_W = 2
);
  logic [OP_W-1:0] op;
  logic            mem_ready;
  logic            pc_write;
  logic            ir_write;
  logic            mem_read;
  logic            mem_write;
  logic [1:0]      alu_op;
  logic            alu_src;
  logic            branch;
  logic            reg_write;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            trap;
  logic [1:0]      cause;

  modport master (
    input  op, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, alu_op, alu_src,
           branch, reg_write, reg_dst, mem_to_reg, trap, cause
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, alu_op, alu_src,
           branch, reg_write, reg_dst, mem_to_reg, trap, cause
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational strobe map: (state, latched opcode, mem_ready) -> datapath
// strobes. Holds no state of its own.
module control_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W      = 2,
  parameter int OP_RTYPE  = DEF_OP_RTYPE,
  parameter int OP_LOAD   = DEF_OP_LOAD,
  parameter int OP_STORE  = DEF_OP_STORE,
  parameter int OP_BRANCH = DEF_OP_BRANCH
) (
  input  state_t          state,
  input  logic [OP_W-1:0] opQ,
  input  logic            memReady,
  output strobes_t        strobes
);

  localparam logic [OP_W-1:0] OPC_R = OP_W'(OP_RTYPE);
  localparam logic [OP_W-1:0] OPC_L = OP_W'(OP_LOAD);
  localparam logic [OP_W-1:0] OPC_S = OP_W'(OP_STORE);
  localparam logic [OP_W-1:0] OPC_B = OP_W'(OP_BRANCH);

  always_comb begin
    strobes = '0;
    case (state)
      ST_FETCH: begin
        strobes.memRead = 1'b1;
        // IR and PC commit in the very cycle the fetch completes.
        if (memReady) begin
          strobes.irWrite = 1'b1;
          strobes.pcWrite = 1'b1;
        end
      end
      ST_EXEC: begin
        if (opQ == OPC_R) begin
          strobes.aluOp  = ALU_FUNCT;
          strobes.aluSrc = 1'b0;
        end else if (opQ == OPC_L || opQ == OPC_S) begin
          strobes.aluOp  = ALU_ADD;
          strobes.aluSrc = 1'b1;
        end else if (opQ == OPC_B) begin
          strobes.aluOp  = ALU_SUB;
          strobes.aluSrc = 1'b0;
          strobes.branch = 1'b1;
        end
      end
      ST_MEM: begin
        if (opQ == OPC_L) begin
          strobes.memRead = 1'b1;
        end else if (opQ == OPC_S) begin
          strobes.memWrite = 1'b1;
        end
      end
      ST_WB: begin
        strobes.regWrite = 1'b1;
        if (opQ == OPC_R) begin
          strobes.regDst   = 1'b1;
          strobes.memToReg = 1'b0;
        end else if (opQ == OPC_L) begin
          strobes.regDst   = 1'b0;
          strobes.memToReg = 1'b1;
        end
      end
      default: strobes = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, bounds each
// memory wait with a timeout and parks in a sticky TRAP on faults.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_W      = 2,
  parameter int OP_RTYPE  = DEF_OP_RTYPE,
  parameter int OP_LOAD   = DEF_OP_LOAD,
  parameter int OP_STORE  = DEF_OP_STORE,
  parameter int OP_BRANCH = DEF_OP_BRANCH,
  parameter int TIMEOUT   = 15
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  localparam int CNT_W = cntWidth(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  localparam logic [OP_W-1:0] OPC_R = OP_W'(OP_RTYPE);
  localparam logic [OP_W-1:0] OPC_L = OP_W'(OP_LOAD);
  localparam logic [OP_W-1:0] OPC_S = OP_W'(OP_STORE);
  localparam logic [OP_W-1:0] OPC_B = OP_W'(OP_BRANCH);

  state_t          state;
  state_t          stateNext;
  logic [OP_W-1:0] op_q;
  logic [CNT_W-1:0] waitCnt;
  logic            trapQ;
  logic [1:0]      causeQ;
  logic [1:0]      causeNext;
  logic            timeoutHit;
  logic            opLegal;
  logic            waiting;
  strobes_t        strobes;

  // The final wait cycle is the one that would push the count to TIMEOUT;
  // a mem_ready in that same cycle still completes the access.
  assign timeoutHit = (TIMEOUT != 0) && !bus.mem_ready && (waitCnt == CNT_LAST);
  assign waiting    = (state == ST_FETCH || state == ST_MEM) && !bus.mem_ready;
  assign opLegal    = (bus.op == OPC_R) || (bus.op == OPC_L) ||
                      (bus.op == OPC_S) || (bus.op == OPC_B);

  always_comb begin
    stateNext = state;
    causeNext = causeQ;
    case (state)
      ST_IDLE:   stateNext = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready) begin
          stateNext = ST_DECODE;
        end else if (timeoutHit) begin
          stateNext = ST_TRAP;
          causeNext = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (opLegal) begin
          stateNext = ST_EXEC;
        end else begin
          stateNext = ST_TRAP;
          causeNext = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (op_q == OPC_R) begin
          stateNext = ST_WB;
        end else if (op_q == OPC_L || op_q == OPC_S) begin
          stateNext = ST_MEM;
        end else begin
          stateNext = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          stateNext = (op_q == OPC_L) ? ST_WB : ST_FETCH;
        end else if (timeoutHit) begin
          stateNext = ST_TRAP;
          causeNext = CAUSE_TIMEOUT;
        end
      end
      ST_WB:     stateNext = ST_FETCH;
      ST_TRAP:   stateNext = ST_TRAP;
      default:   stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      waitCnt <= '0;
      trapQ   <= 1'b0;
      causeQ  <= CAUSE_NONE;
    end else begin
      state  <= stateNext;
      causeQ <= causeNext;
      if (stateNext == ST_TRAP) begin
        trapQ <= 1'b1;
      end
      if (state == ST_DECODE) begin
        op_q <= bus.op;
      end
      // Every state change restarts the wait count, so FETCH and MEM always
      // begin counting from zero.
      if (stateNext != state) begin
        waitCnt <= '0;
      end else if (waiting && waitCnt != CNT_MAX) begin
        waitCnt <= waitCnt + 1'b1;
      end
    end
  end

  control_decode #(
    .OP_W      (OP_W),
    .OP_RTYPE  (OP_RTYPE),
    .OP_LOAD   (OP_LOAD),
    .OP_STORE  (OP_STORE),
    .OP_BRANCH (OP_BRANCH)
  ) uDecode (
    .state    (state),
    .opQ      (op_q),
    .memReady (bus.mem_ready),
    .strobes  (strobes)
  );

  assign bus.pc_write   = strobes.pcWrite;
  assign bus.ir_write   = strobes.irWrite;
  assign bus.mem_read   = strobes.memRead;
  assign bus.mem_write  = strobes.memWrite;
  assign bus.alu_op     = strobes.aluOp;
  assign bus.alu_src    = strobes.aluSrc;
  assign bus.branch     = strobes.branch;
  assign bus.reg_write  = strobes.regWrite;
  assign bus.reg_dst    = strobes.regDst;
  assign bus.mem_to_reg = strobes.memToReg;
  assign bus.trap       = trapQ;
  assign bus.cause      = causeQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector tables for the corner cases
// plus random instruction streams expanded into expected per-cycle strobes.
module tb_multicycle_control;

  localparam int OP_W    = 3;
  localparam int TIMEOUT = 4;

  // Output vector layout: {pc_write, ir_write, mem_read, mem_write} _
  // alu_op _ {alu_src, branch, reg_write, reg_dst, mem_to_reg, trap} _ cause
  localparam logic [13:0] O_Z      = 14'b0000_00_000000_00;
  localparam logic [13:0] O_FWAIT  = 14'b0010_00_000000_00;
  localparam logic [13:0] O_FREADY = 14'b1110_00_000000_00;
  localparam logic [13:0] O_EXR    = 14'b0000_10_000000_00;
  localparam logic [13:0] O_EXLS   = 14'b0000_00_100000_00;
  localparam logic [13:0] O_EXB    = 14'b0000_01_010000_00;
  localparam logic [13:0] O_MRD    = 14'b0010_00_000000_00;
  localparam logic [13:0] O_MWR    = 14'b0001_00_000000_00;
  localparam logic [13:0] O_WBR    = 14'b0000_00_001100_00;
  localparam logic [13:0] O_WBL    = 14'b0000_00_001010_00;
  localparam logic [13:0] O_TILL   = 14'b0000_00_000001_01;
  localparam logic [13:0] O_TTO    = 14'b0000_00_000001_10;

  typedef struct {
    logic        rstn;
    logic [2:0]  op;
    logic        rdy;
    logic [13:0] want;
  } vec_t;

  vec_t  q[$];
  string phase;
  int    nVec = 0;
  int    nErr = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if #(.OP_W(OP_W)) bus ();

  multicycle_control #(
    .OP_W    (OP_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic int ro();
    return int'($urandom_range(0, 7));
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic pushV(input bit rstn, input int op, input bit rdy, input logic [13:0] want);
    vec_t v;
    v.rstn = rstn;
    v.op   = 3'(op);
    v.rdy  = rdy;
    v.want = want;
    q.push_back(v);
  endtask

  task automatic runQ();
    logic [13:0] act;
    for (int i = 0; i < q.size(); i++) begin
      rst_n         = q[i].rstn;
      bus.op        = q[i].op;
      bus.mem_ready = q[i].rdy;
      @(negedge clk);
      act = {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.alu_op,
             bus.alu_src, bus.branch, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
             bus.trap, bus.cause};
      nVec++;
      if (act !== q[i].want) begin
        nErr++;
        $display("FAIL %s[%0d] outputs got %b want %b (rst_n=%b op=%0d rdy=%b)",
                 phase, i, act, q[i].want, q[i].rstn, q[i].op, q[i].rdy);
      end
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  // Reference model: a trapped unit sits in TRAP for a while, then is reset.
  task automatic trapPhase(input logic [13:0] want);
    int n = int'($urandom_range(2, 4));
    repeat (n) pushV(1, ro(), rb(), want);
    pushV(0, ro(), rb(), O_Z);
    pushV(1, ro(), rb(), O_Z);
  endtask

  // A memory access that waits w cycles; w >= TIMEOUT means the timeout fires.
  task automatic memPhase(output bit trapped, input logic [13:0] waitV,
                          input logic [13:0] readyV, input int w);
    if (w >= TIMEOUT) begin
      repeat (TIMEOUT) pushV(1, ro(), 0, waitV);
      trapPhase(O_TTO);
      trapped = 1'b1;
    end else begin
      repeat (w) pushV(1, ro(), 0, waitV);
      pushV(1, ro(), 1, readyV);
      trapped = 1'b0;
    end
  endtask

  task automatic instr(input int op, input int wF, input int wM);
    bit t;
    memPhase(t, O_FWAIT, O_FREADY, wF);
    if (t) return;
    pushV(1, op, rb(), O_Z);
    if (op > 3) begin
      trapPhase(O_TILL);
      return;
    end
    case (op)
      0: begin
        pushV(1, ro(), rb(), O_EXR);
        pushV(1, ro(), rb(), O_WBR);
      end
      1: begin
        pushV(1, ro(), rb(), O_EXLS);
        memPhase(t, O_MRD, O_MRD, wM);
        if (!t) pushV(1, ro(), rb(), O_WBL);
      end
      2: begin
        pushV(1, ro(), rb(), O_EXLS);
        memPhase(t, O_MWR, O_MWR, wM);
      end
      default: pushV(1, ro(), rb(), O_EXB);
    endcase
  endtask

  function automatic int rndWait();
    if ($urandom_range(0, 11) == 0) return int'($urandom_range(TIMEOUT, TIMEOUT + 2));
    return int'($urandom_range(0, TIMEOUT - 1));
  endfunction

  initial begin
    rst_n         = 1'b0;
    bus.op        = '0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // R-type, then load with 3 MEM waits, store, branch; op is junk outside DECODE.
    phase = "basic";
    pushV(0, 0, 0, O_Z);
    pushV(1, 7, 1, O_Z);
    pushV(1, 7, 1, O_FREADY);
    pushV(1, 0, 1, O_Z);
    pushV(1, 7, 0, O_EXR);
    pushV(1, 7, 1, O_WBR);
    pushV(1, 7, 1, O_FREADY);
    pushV(1, 1, 0, O_Z);
    pushV(1, 7, 1, O_EXLS);
    pushV(1, 7, 0, O_MRD);
    pushV(1, 7, 0, O_MRD);
    pushV(1, 7, 0, O_MRD);
    pushV(1, 7, 1, O_MRD);
    pushV(1, 7, 0, O_WBL);
    pushV(1, 7, 1, O_FREADY);
    pushV(1, 2, 0, O_Z);
    pushV(1, 7, 0, O_EXLS);
    pushV(1, 7, 1, O_MWR);
    pushV(1, 7, 1, O_FREADY);
    pushV(1, 3, 1, O_Z);
    pushV(1, 7, 1, O_EXB);
    pushV(1, 7, 0, O_FWAIT);
    runQ();

    phase = "illegal";
    pushV(0, 0, 0, O_Z);
    pushV(1, 0, 0, O_Z);
    pushV(1, 0, 1, O_FREADY);
    pushV(1, 5, 1, O_Z);
    repeat (20) pushV(1, ro(), rb(), O_TILL);
    pushV(0, 0, 1, O_Z);
    pushV(1, 0, 1, O_Z);
    pushV(1, 0, 1, O_FREADY);
    runQ();

    phase = "fetch_timeout";
    pushV(0, 0, 0, O_Z);
    pushV(1, 0, 0, O_Z);
    repeat (4) pushV(1, 0, 0, O_FWAIT);
    repeat (3) pushV(1, ro(), rb(), O_TTO);
    pushV(0, 0, 0, O_Z);
    pushV(1, 0, 0, O_Z);
    repeat (3) pushV(1, 0, 0, O_FWAIT);
    pushV(1, 7, 1, O_FREADY);
    pushV(1, 0, 0, O_Z);
    pushV(1, 7, 0, O_EXR);
    runQ();

    phase = "mem_timeout";
    pushV(0, 0, 0, O_Z);
    pushV(1, 0, 0, O_Z);
    pushV(1, 0, 1, O_FREADY);
    pushV(1, 1, 1, O_Z);
    pushV(1, 7, 1, O_EXLS);
    repeat (4) pushV(1, 7, 0, O_MRD);
    repeat (2) pushV(1, 7, 1, O_TTO);
    runQ();

    phase = "reset_in_mem";
    pushV(0, 0, 0, O_Z);
    pushV(1, 0, 0, O_Z);
    pushV(1, 0, 1, O_FREADY);
    pushV(1, 2, 0, O_Z);
    pushV(1, 7, 0, O_EXLS);
    pushV(1, 7, 0, O_MWR);
    pushV(0, 7, 1, O_Z);
    pushV(1, 7, 1, O_Z);
    pushV(1, 7, 1, O_FREADY);
    pushV(1, 3, 0, O_Z);
    pushV(1, 7, 0, O_EXB);
    runQ();

    phase = "random";
    pushV(0, ro(), rb(), O_Z);
    pushV(1, ro(), rb(), O_Z);
    for (int k = 0; k < 300; k++) begin
      int op;
      op = ($urandom_range(0, 11) == 0) ? int'($urandom_range(4, 7))
                                        : int'($urandom_range(0, 3));
      instr(op, rndWait(), rndWait());
    end
    runQ();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
